vending_ctrl_param: RTL and testbench

- Parametrised vending-machine controller. Consumes one-cycle decoded key events from the keypad/debounce front end and sequences these steps: product select, price view, quantity select, confirm, coin payment, dispense.
- Adds behaviour the fixed controller lacks: parameter-driven price table and product count, multiplied total, change and refund outputs, cancel key, and an inactivity timeout.
- Binary display and state-code outputs feed the existing binary2bcd / seven_segment chain.

---
 rtl/vending_pkg.sv | 43 ++++
 rtl/vend_timeout.sv | 34 +++
 rtl/vending_ctrl_param.sv | 196 +++++++++++++++++++
 tb/tb_vending_ctrl_param.sv | 280 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/vending_pkg.sv
`default_nettype none
// ----------------------------------------------------------------------------
// vending_pkg : state encoding, key codes and coin values for vending_ctrl_param
// Revision    : 1.0
// ----------------------------------------------------------------------------
package vending_pkg;

  typedef enum logic [2:0] {
    S_IDLE     = 3'd0,
    S_SELECT   = 3'd1,
    S_VIEW     = 3'd2,
    S_QTY      = 3'd3,
    S_CONFIRM  = 3'd4,
    S_PAY      = 3'd5,
    S_DISPENSE = 3'd6,
    S_REFUND   = 3'd7
  } state_t;

  localparam logic [3:0] KEY_C2      = 4'h8;
  localparam logic [3:0] KEY_C5      = 4'h9;
  localparam logic [3:0] KEY_C10     = 4'hA;
  localparam logic [3:0] KEY_QTY     = 4'hB;
  localparam logic [3:0] KEY_CANCEL  = 4'hC;
  localparam logic [3:0] KEY_TAKE    = 4'hD;
  localparam logic [3:0] KEY_CONFIRM = 4'hE;
  localparam logic [3:0] KEY_OK      = 4'hF;

  localparam int COIN_C2  = 2;
  localparam int COIN_C5  = 5;
  localparam int COIN_C10 = 10;

  // Non-coin keys are worth nothing.
  function automatic int coin_value(input logic [3:0] k);
    case (k)
      KEY_C2:  coin_value = COIN_C2;
      KEY_C5:  coin_value = COIN_C5;
      KEY_C10: coin_value = COIN_C10;
      default: coin_value = 0;
    endcase
  endfunction

endpackage
`default_nettype wire

// File: rtl/vend_timeout.sv
`default_nettype none
// ----------------------------------------------------------------------------
// vend_timeout : idle-cycle counter, pulses expire after TIMEOUT_CYC enabled cycles
// Revision     : 1.0
// ----------------------------------------------------------------------------
module vend_timeout #(
  parameter int TIMEOUT_CYC = 50000000
) (
  input  logic clk,
  input  logic reset,
  input  logic clr,
  input  logic en,
  output logic expire
);

  localparam int CW = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;
  localparam logic [CW-1:0] C_LAST = CW'(TIMEOUT_CYC - 1);

  logic [CW-1:0] r_count;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_count <= '0;
    end else if (clr) begin
      r_count <= '0;
    end else if (en && (r_count != C_LAST)) begin
      r_count <= r_count + 1'b1;
    end
  end

  assign expire = en && (r_count == C_LAST);

endmodule
`default_nettype wire

// File: rtl/vending_ctrl_param.sv
`default_nettype none
// ----------------------------------------------------------------------------
// vending_ctrl_param : parametrised vending controller (select, qty, pay, dispense)
// Revision           : 1.0
// ----------------------------------------------------------------------------
module vending_ctrl_param #(
  parameter int N_PROD      = 5,
  parameter int PRICE_W     = 8,
  // Product 1 sits in the low slice: prices 1, 2, 5, 10, 6 for products 1..5.
  parameter logic [N_PROD*PRICE_W-1:0] PRICE_TABLE = {8'd6, 8'd10, 8'd5, 8'd2, 8'd1},
  parameter int MAX_QTY     = 3,
  parameter int AMT_W       = 10,
  parameter int TIMEOUT_CYC = 50000000
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             key_valid,
  input  logic [3:0]       key_code,
  output logic [AMT_W-1:0] display_value,
  output logic [2:0]       state_code,
  output logic [3:0]       product_id,
  output logic [3:0]       qty,
  output logic             dispense,
  output logic             change_valid,
  output logic [AMT_W-1:0] change_amount,
  output logic             busy
);

  import vending_pkg::*;

  localparam int MUL_W = (((PRICE_W + 4) > AMT_W) ? (PRICE_W + 4) : AMT_W) + 1;
  localparam logic [AMT_W-1:0] C_AMT_MAX = {AMT_W{1'b1}};

  state_t           r_state, w_state_nxt;
  logic [3:0]       r_pid, w_pid_nxt, r_qty, w_qty_nxt;
  logic [AMT_W-1:0] r_total, w_total_nxt, r_paid, w_paid_nxt;
  logic [AMT_W-1:0] r_change, w_change_nxt, r_camt, w_camt_nxt;
  logic             r_disp, w_disp_nxt, r_cv, w_cv_nxt;
  logic             w_expire, w_tmo, w_clr, w_en, w_is_coin;
  logic [MUL_W-1:0] w_prod;
  logic [AMT_W-1:0] w_total_sat, w_paid_add;
  logic [AMT_W:0]   w_sum;

  function automatic logic [PRICE_W-1:0] price_of(input logic [3:0] k);
    price_of = '0;
    for (int i = 0; i < N_PROD; i++) begin
      if (k == 4'(i + 1)) price_of = PRICE_TABLE[i*PRICE_W +: PRICE_W];
    end
  endfunction

  assign w_prod      = MUL_W'(price_of(r_pid)) * MUL_W'(r_qty);
  assign w_total_sat = (w_prod > MUL_W'(C_AMT_MAX)) ? C_AMT_MAX : w_prod[AMT_W-1:0];
  assign w_sum       = {1'b0, r_paid} + (AMT_W + 1)'(coin_value(key_code));
  assign w_paid_add  = w_sum[AMT_W] ? C_AMT_MAX : w_sum[AMT_W-1:0];
  assign w_is_coin   = (key_code == KEY_C2) || (key_code == KEY_C5) || (key_code == KEY_C10);

  // A key in the expiry cycle wins over the timeout.
  assign w_tmo = w_expire && !key_valid;
  assign w_clr = key_valid || (w_state_nxt != r_state);
  assign w_en  = (r_state != S_IDLE) && (r_state != S_DISPENSE);

  vend_timeout #(.TIMEOUT_CYC(TIMEOUT_CYC)) u_timeout (
    .clk    (clk),
    .reset  (reset),
    .clr    (w_clr),
    .en     (w_en),
    .expire (w_expire)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state  <= S_IDLE;
      r_pid    <= '0;
      r_qty    <= '0;
      r_total  <= '0;
      r_paid   <= '0;
      r_change <= '0;
      r_camt   <= '0;
      r_disp   <= 1'b0;
      r_cv     <= 1'b0;
    end else begin
      r_state  <= w_state_nxt;
      r_pid    <= w_pid_nxt;
      r_qty    <= w_qty_nxt;
      r_total  <= w_total_nxt;
      r_paid   <= w_paid_nxt;
      r_change <= w_change_nxt;
      r_camt   <= w_camt_nxt;
      r_disp   <= w_disp_nxt;
      r_cv     <= w_cv_nxt;
    end
  end

  always_comb begin
    w_state_nxt  = r_state;
    w_pid_nxt    = r_pid;
    w_qty_nxt    = r_qty;
    w_total_nxt  = r_total;
    w_paid_nxt   = r_paid;
    w_change_nxt = r_change;
    w_camt_nxt   = r_camt;
    w_disp_nxt   = 1'b0;
    w_cv_nxt     = 1'b0;
    case (r_state)
      S_IDLE: if (key_valid && key_code == KEY_OK) begin
        w_state_nxt = S_SELECT;
        w_pid_nxt   = '0;
        w_qty_nxt   = '0;
        w_camt_nxt  = '0;
      end
      S_SELECT: if (key_valid) begin
        if (key_code == KEY_CANCEL) begin
          w_state_nxt = S_IDLE;
        end else if (key_code != 4'd0 && key_code <= 4'(N_PROD)) begin
          w_pid_nxt   = key_code;
          w_state_nxt = S_VIEW;
        end
      end
      S_VIEW: if (key_valid) begin
        if (key_code == KEY_OK) begin
          w_qty_nxt   = 4'd1;
          w_state_nxt = S_QTY;
        end else if (key_code == KEY_CANCEL) begin
          w_state_nxt = S_IDLE;
        end
      end
      S_QTY: if (key_valid) begin
        if (key_code == KEY_QTY) begin
          w_qty_nxt = (r_qty >= 4'(MAX_QTY)) ? 4'd1 : r_qty + 4'd1;
        end else if (key_code == KEY_OK) begin
          w_total_nxt = w_total_sat;
          w_state_nxt = S_CONFIRM;
        end else if (key_code == KEY_CANCEL) begin
          w_state_nxt = S_IDLE;
        end
      end
      S_CONFIRM: if (key_valid) begin
        if (key_code == KEY_CONFIRM) begin
          w_paid_nxt  = '0;
          w_state_nxt = S_PAY;
        end else if (key_code == KEY_CANCEL) begin
          w_state_nxt = S_IDLE;
        end
      end
      S_PAY: if (key_valid) begin
        if (w_is_coin) begin
          w_paid_nxt = w_paid_add;
          if (w_paid_add >= r_total) begin
            w_change_nxt = w_paid_add - r_total;
            w_state_nxt  = S_DISPENSE;
          end
        end else if (key_code == KEY_CANCEL) begin
          w_state_nxt = (r_paid != '0) ? S_REFUND : S_IDLE;
        end
      end
      S_DISPENSE: if (key_valid && key_code == KEY_TAKE) begin
        w_disp_nxt  = 1'b1;
        w_cv_nxt    = 1'b1;
        w_camt_nxt  = r_change;
        w_state_nxt = S_IDLE;
      end
      S_REFUND: begin
        w_cv_nxt    = 1'b1;
        w_camt_nxt  = r_paid;
        w_state_nxt = S_IDLE;
      end
      default: w_state_nxt = S_IDLE;
    endcase
    if (w_tmo) begin
      w_state_nxt = (r_state == S_PAY && r_paid != '0) ? S_REFUND : S_IDLE;
    end
  end

  always_comb begin
    display_value = '0;
    case (r_state)
      S_VIEW:     display_value = AMT_W'(price_of(r_pid));
      S_QTY:      display_value = AMT_W'(r_qty);
      S_CONFIRM:  display_value = r_total;
      S_PAY:      display_value = r_paid;
      S_DISPENSE: display_value = r_change;
      S_REFUND:   display_value = r_paid;
      default:    display_value = '0;
    endcase
  end

  assign state_code    = r_state;
  assign busy          = (r_state != S_IDLE);
  assign product_id    = r_pid;
  assign qty           = r_qty;
  assign dispense      = r_disp;
  assign change_valid  = r_cv;
  assign change_amount = r_camt;

endmodule
`default_nettype wire

// File: tb/tb_vending_ctrl_param.sv
`default_nettype none
// ----------------------------------------------------------------------------
// tb_vending_ctrl_param : directed and random checks against a transaction-level model
// Revision              : 1.0
// ----------------------------------------------------------------------------
module tb_vending_ctrl_param;

  localparam int N_PROD = 5;
  localparam int PRICE_W = 8;
  localparam int MAX_QTY = 3;
  localparam int AMT_W = 10;
  localparam int TO = 20;
  localparam logic [N_PROD*PRICE_W-1:0] PT = {8'd6, 8'd10, 8'd5, 8'd2, 8'd1};

  logic             clk = 1'b0;
  logic             reset;
  logic             key_valid;
  logic [3:0]       key_code;
  logic [AMT_W-1:0] display_value;
  logic [2:0]       state_code;
  logic [3:0]       product_id;
  logic [3:0]       qty;
  logic             dispense;
  logic             change_valid;
  logic [AMT_W-1:0] change_amount;
  logic             busy;

  vending_ctrl_param #(
    .N_PROD(N_PROD), .PRICE_W(PRICE_W), .PRICE_TABLE(PT),
    .MAX_QTY(MAX_QTY), .AMT_W(AMT_W), .TIMEOUT_CYC(TO)
  ) dut (
    .clk(clk), .reset(reset), .key_valid(key_valid), .key_code(key_code),
    .display_value(display_value), .state_code(state_code), .product_id(product_id),
    .qty(qty), .dispense(dispense), .change_valid(change_valid),
    .change_amount(change_amount), .busy(busy)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad = 0;
  int price_tab [1:5] = '{1, 2, 5, 10, 6};
  int amt_max = (1 << AMT_W) - 1;

  // Transaction-level model: step name, chosen product, money in flight.
  int m_st, m_pid, m_qty, m_total, m_paid, m_change, m_camt, m_disp, m_cv, m_cnt;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_st = 0; m_pid = 0; m_qty = 0; m_total = 0; m_paid = 0;
    m_change = 0; m_camt = 0; m_disp = 0; m_cv = 0; m_cnt = 0;
  endtask

  task automatic model_step(input logic kv, input logic [3:0] kc);
    int ns, k, coin;
    bit tmo;
    k = int'(kc);
    ns = m_st;
    m_disp = 0;
    m_cv = 0;
    tmo = !kv && m_st != 0 && m_st != 6 && m_cnt == TO - 1;
    coin = (k == 8) ? 2 : (k == 9) ? 5 : (k == 10) ? 10 : 0;
    case (m_st)
      0: if (kv && k == 15) begin ns = 1; m_pid = 0; m_qty = 0; m_camt = 0; end
      1: if (kv) begin
           if (k == 12) ns = 0;
           else if (k >= 1 && k <= N_PROD) begin m_pid = k; ns = 2; end
         end
      2: if (kv) begin
           if (k == 15) begin m_qty = 1; ns = 3; end
           else if (k == 12) ns = 0;
         end
      3: if (kv) begin
           if (k == 11) m_qty = (m_qty == MAX_QTY) ? 1 : m_qty + 1;
           else if (k == 15) begin
             m_total = price_tab[m_pid] * m_qty;
             if (m_total > amt_max) m_total = amt_max;
             ns = 4;
           end else if (k == 12) ns = 0;
         end
      4: if (kv) begin
           if (k == 14) begin m_paid = 0; ns = 5; end
           else if (k == 12) ns = 0;
         end
      5: if (kv) begin
           if (coin != 0) begin
             m_paid = m_paid + coin;
             if (m_paid > amt_max) m_paid = amt_max;
             if (m_paid >= m_total) begin m_change = m_paid - m_total; ns = 6; end
           end else if (k == 12) ns = (m_paid > 0) ? 7 : 0;
         end
      6: if (kv && k == 13) begin m_disp = 1; m_cv = 1; m_camt = m_change; ns = 0; end
      default: begin m_cv = 1; m_camt = m_paid; ns = 0; end
    endcase
    if (tmo) ns = (m_st == 5 && m_paid > 0) ? 7 : 0;
    if (kv || ns != m_st) m_cnt = 0;
    else if (m_st != 0 && m_st != 6) m_cnt = m_cnt + 1;
    m_st = ns;
  endtask

  function automatic int exp_display();
    case (m_st)
      2: return price_tab[m_pid];
      3: return m_qty;
      4: return m_total;
      5: return m_paid;
      6: return m_change;
      7: return m_paid;
      default: return 0;
    endcase
  endfunction

  task automatic check_all();
    chk("state_code", state_code, m_st);
    chk("display_value", display_value, exp_display());
    chk("product_id", product_id, m_pid);
    chk("qty", qty, m_qty);
    chk("dispense", dispense, m_disp);
    chk("change_valid", change_valid, m_cv);
    chk("change_amount", change_amount, m_camt);
    chk("busy", busy, (m_st != 0) ? 1 : 0);
  endtask

  task automatic tick(input logic kv, input logic [3:0] kc);
    key_valid = kv;
    key_code = kc;
    @(posedge clk);
    model_step(kv, kc);
    #1;
    check_all();
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  logic [3:0] bias_keys [8] = '{4'hF, 4'hE, 4'hD, 4'hB, 4'h8, 4'h9, 4'hA, 4'h2};

  initial begin
    reset = 1'b0;
    key_valid = 1'b0;
    key_code = 4'd0;
    model_reset();
    repeat (3) @(posedge clk);
    #1;
    check_all();
    #2 reset = 1'b1;

    // Ignored keys: invalid key_valid, out-of-range product, coins in SELECT.
    tick(1'b0, 4'hF);
    chk("idle_no_valid", state_code, 0);
    tick(1'b1, 4'hF);
    tick(1'b1, 4'd7);
    tick(1'b1, 4'h8);
    tick(1'b1, 4'h9);
    tick(1'b1, 4'hA);
    chk("select_ignore", state_code, 1);

    // Basic purchase: product 2 (price 2), pay 10, change 8.
    tick(1'b1, 4'd2);
    chk("view_price", display_value, 2);
    tick(1'b1, 4'hF);
    tick(1'b1, 4'hF);
    tick(1'b1, 4'hE);
    tick(1'b1, 4'hA);
    chk("basic_to_dispense", state_code, 6);
    chk("basic_change_disp", display_value, 8);
    tick(1'b1, 4'hD);
    chk("basic_dispense", dispense, 1);
    chk("basic_cv", change_valid, 1);
    chk("basic_camt", change_amount, 8);
    chk("basic_idle", state_code, 0);
    tick(1'b0, 4'h0);
    chk("dispense_one_pulse", dispense, 0);

    // Quantity wrap and total on product 5 (price 6).
    tick(1'b1, 4'hF);
    tick(1'b1, 4'd5);
    tick(1'b1, 4'hF);
    tick(1'b1, 4'hB);
    chk("qty_2", qty, 2);
    tick(1'b1, 4'hB);
    chk("qty_3", qty, 3);
    tick(1'b1, 4'hB);
    chk("qty_wrap", qty, 1);
    tick(1'b1, 4'hB);
    tick(1'b1, 4'hF);
    chk("total_12", display_value, 12);
    tick(1'b1, 4'hC);

    // Cancel in PAY with coins -> refund.
    tick(1'b1, 4'hF);
    tick(1'b1, 4'd3);
    tick(1'b1, 4'hF);
    tick(1'b1, 4'hF);
    tick(1'b1, 4'hE);
    tick(1'b1, 4'h8);
    chk("paid_2", display_value, 2);
    tick(1'b1, 4'hC);
    chk("refund_state", state_code, 7);
    tick(1'b0, 4'h0);
    chk("refund_cv", change_valid, 1);
    chk("refund_camt", change_amount, 2);
    chk("refund_no_disp", dispense, 0);
    chk("refund_idle", state_code, 0);

    // Timeout in PAY with paid 5.
    tick(1'b1, 4'hF);
    tick(1'b1, 4'd4);
    tick(1'b1, 4'hF);
    tick(1'b1, 4'hF);
    tick(1'b1, 4'hE);
    tick(1'b1, 4'h9);
    repeat (TO - 1) tick(1'b0, 4'h0);
    chk("pay_before_to", state_code, 5);
    tick(1'b0, 4'h0);
    chk("pay_to_refund", state_code, 7);
    tick(1'b0, 4'h0);
    chk("pay_to_cv", change_valid, 1);
    chk("pay_to_camt", change_amount, 5);

    // Timeout in QTY, with a key in the expiry cycle restarting the count.
    tick(1'b1, 4'hF);
    tick(1'b1, 4'd1);
    tick(1'b1, 4'hF);
    repeat (TO - 1) tick(1'b0, 4'h0);
    tick(1'b1, 4'd5);
    chk("key_beats_timeout", state_code, 3);
    repeat (TO - 1) tick(1'b0, 4'h0);
    chk("qty_before_to", state_code, 3);
    tick(1'b0, 4'h0);
    chk("qty_to_idle", state_code, 0);

    // Asynchronous reset mid-PAY.
    tick(1'b1, 4'hF);
    tick(1'b1, 4'd4);
    tick(1'b1, 4'hF);
    tick(1'b1, 4'hF);
    tick(1'b1, 4'hE);
    tick(1'b1, 4'h8);
    key_valid = 1'b0;
    #2 reset = 1'b0;
    #1;
    model_reset();
    check_all();
    repeat (2) begin
      @(posedge clk);
      #1;
      chk("reset_no_cv", change_valid, 0);
    end
    #2 reset = 1'b1;
    tick(1'b0, 4'h0);
    chk("after_reset_idle", state_code, 0);

    // Random traffic, biased toward useful keys, with idle bursts for timeouts.
    for (int i = 0; i < 800; i++) begin
      if ($urandom_range(0, 24) == 0) begin
        repeat (TO + 3) tick(1'b0, 4'($urandom_range(0, 15)));
      end else if ($urandom_range(0, 1) == 0) begin
        tick(($urandom_range(0, 3) != 0), bias_keys[$urandom_range(0, 7)]);
      end else begin
        tick(($urandom_range(0, 3) != 0), 4'($urandom_range(0, 15)));
      end
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
